vert_ucode_quicksort_asm: RTL and testbench
===========================================

Name: vert_ucode_quicksort_asm

Overview:
Microcode assembler/loader for the vertical-ucode quicksort engine. It is the encoding counterpart of the package `decode` function. It accepts one mnemonic-level instruction per handshake and packs it into the 16-bit `inst_t` format. Each encoded word is written into the program store at consecutive `pc_t` addresses. A bench or boot sequencer uses it to download microprograms before sorting starts.

Parameters:
PC_W, 8, program address width (matches `pc_t`)
INST_W, 16, instruction width (matches `$bits(inst_t)`)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a program at start_addr; honoured only in IDLE
start_addr  in  PC_W  first write address
in_vld  in  1  instruction valid
in_rdy  out  1  instruction accepted when in_vld&in_rdy
in_op  in  4  0 NOP, 1 JCC, 2 PUSH, 3 POP, 4 LD, 5 ST, 6 MOV, 7 MOVI, 8 MOVS, 9 ADD, 10 SUB, 11 CALL, 12 RET, 13 EMIT, 14 WAIT, 15 illegal
in_dst  in  3  reg_t destination / push-pop register
in_src0  in  3  reg_t source 0
in_src1  in  3  reg_t source 1
in_imm  in  3  imm_t
in_special  in  3  reg_special_t
in_cc  in  2  cc_t
in_target  in  8  field_A_t
in_use_imm  in  1  ADD/SUB: use in_imm instead of in_src1
in_wren  in  1  ADD/SUB: write-back enable (W bit)
in_last  in  1  final instruction of program
wr_vld  out  1  program-store write valid
wr_rdy  in  1  program-store accepts write
wr_addr  out  PC_W  write address
wr_data  out  INST_W  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on program completion
err  out  1  sticky; cleared by start
prog_len  out  PC_W+1  words written this program

Behaviour:
- Reset (rst_n=0 at clk edge), including mid-program:
  - state=IDLE
  - in_rdy=0, wr_vld=0, wr_addr=0, wr_data=0
  - done=0, err=0, prog_len=0, busy=0
- States:
  - IDLE -> LOAD on start. Loads wr pointer=start_addr and prog_len=0, clears err.
  - LOAD -> FLUSH when the in_last beat is accepted.
  - FLUSH -> IDLE once the output register is empty. done=1 for exactly that one cycle.
  - start outside IDLE is ignored.
- Handshake:
  - in_rdy = (state==LOAD) & (~wr_vld | wr_rdy). This is combinational from state and the output register only, never from in_vld.
  - Accepted beat is registered: wr_vld/wr_addr/wr_data appear the next cycle (latency 1).
  - Output holds stable while wr_vld & ~wr_rdy.
  - A write completes on wr_vld & wr_rdy. prog_len increments on each completed write.
  - A new accept and a write completion in the same cycle give full throughput of 1 word/cycle.
- Address: the pointer increments per accepted word.
- Overflow: a beat accepted after address 2^PC_W-1 has been used is dropped (no wr_vld) and sets err. Accepting continues until in_last so the source drains. No wrap to 0.
- Encoding: opcode in [15:12]. Unlisted bits are 0, and unused inputs are ignored.
  - NOP: 0x0000.
  - JCC: 0001, [9:8]=cc, [7:0]=target.
  - PUSH/POP: 0010, [11]=pop, [10:8]=dst.
  - LD/ST: 0100, [11]=st, [10:8]=dst, [6:4]=src0.
  - MOV: 0110, [11]=0, [10:8]=dst, [6:4]=src0.
  - MOVI: 0110, [11]=1, [10:8]=dst, [7]=0, [2:0]=imm.
  - MOVS: 0110, [11]=1, [10:8]=dst, [7]=1, [6:4]=special.
  - ADD/SUB: 0111, [11]=sub, [10:8]=dst, [7]=wren, [6:4]=src0, [3]=use_imm, [2:0]=use_imm?imm:src1.
  - CALL: 1100, [11]=1, [7:0]=target. RET: 0xC000.
  - EMIT: 0xF000. WAIT: 0xF800.
- Illegal op (15): writes 0x0000 and sets err. The word still occupies an address.
- Invariant: `decode(wr_data)` never sets invalid_inst for legal ops.
- Reset wins over all simultaneous events.

Test Plan:
- Reset, then start with start_addr=0x10. Send ADD dst=3 src0=1 src1=2 wren=1, then SUB dst=2 src0=0 imm=5 use_imm=1 wren=0 with last. Expect writes 0x7392@0x10 and 0x7A0D@0x11. Expect done one cycle after the final write; prog_len=2, err=0.
- Send JCC cc=GT target=0x2A, CALL 0x40, RET, POP r6, EMIT, WAIT. Expect 0x122A, 0xC840, 0xC000, 0x2E00, 0xF000, 0xF800 at consecutive addresses. Each decodes back to the same fields.
- Send MOVI r5,7 (with in_src0=4 as noise), then MOVS r1,REG_N. Expect 0x6D07 and 0x6980, confirming noise is masked.
- Hold wr_rdy=0 for 3 cycles with in_vld=1. Expect in_rdy=0 and wr_data/wr_addr stable. After release, no beat is lost or duplicated and back-to-back throughput is 1/cycle.
- Start at 0xFE and send 3 words with last. Expect writes at 0xFE and 0xFF only; the third is dropped. Expect err=1, prog_len=2, done pulses.
- Assert rst_n=0 mid-program with wr_vld=1. Next cycle all outputs are at reset values. A subsequent start works normally and err is cleared.

Source files
------------

// File: rtl/vert_ucode_quicksort_asm_if.sv
// rtl/vert_ucode_quicksort_asm_if.sv - instruction-in / program-store-out bundle for the ucode assembler
//
// Ports (signals):
//   in_vld/in_rdy + in_* fields : one mnemonic-level instruction per handshake
//   in_last                     : marks the final instruction of a program
//   wr_vld/wr_rdy               : program-store write handshake
//   wr_addr/wr_data             : program-store address and encoded instruction
// Modports:
//   master : instruction source and program-store sink (bench / boot sequencer)
//   slave  : the assembler itself
interface vert_ucode_quicksort_asm_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              in_vld;
    logic              in_rdy;
    logic [3:0]        in_op;
    logic [2:0]        in_dst;
    logic [2:0]        in_src0;
    logic [2:0]        in_src1;
    logic [2:0]        in_imm;
    logic [2:0]        in_special;
    logic [1:0]        in_cc;
    logic [7:0]        in_target;
    logic              in_use_imm;
    logic              in_wren;
    logic              in_last;
    logic              wr_vld;
    logic              wr_rdy;
    logic [PC_W-1:0]   wr_addr;
    logic [INST_W-1:0] wr_data;

    modport master (
        output in_vld, in_op, in_dst, in_src0, in_src1, in_imm, in_special,
               in_cc, in_target, in_use_imm, in_wren, in_last, wr_rdy,
        input  in_rdy, wr_vld, wr_addr, wr_data
    );

    modport slave (
        input  in_vld, in_op, in_dst, in_src0, in_src1, in_imm, in_special,
               in_cc, in_target, in_use_imm, in_wren, in_last, wr_rdy,
        output in_rdy, wr_vld, wr_addr, wr_data
    );
endinterface

// File: rtl/vert_ucode_quicksort_asm.sv
// rtl/vert_ucode_quicksort_asm.sv - packs mnemonic instructions into 16-bit ucode words and streams them to the program store
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begin a program at start_addr (only honoured when idle)
//   start_addr  : first program-store address
//   bus         : slave side of the instruction-in / write-out bundle
//   busy        : a program is being loaded or flushed
//   done        : one-cycle pulse when the program has fully drained
//   err         : sticky illegal-op / address-overflow flag, cleared by start
//   prog_len    : words written to the store for the current program
module vert_ucode_quicksort_asm #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [PC_W-1:0]          start_addr,
    vert_ucode_quicksort_asm_if.slave bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [PC_W:0]            prog_len
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JCC  = 4'd1,
        OP_PUSH = 4'd2,
        OP_POP  = 4'd3,
        OP_LD   = 4'd4,
        OP_ST   = 4'd5,
        OP_MOV  = 4'd6,
        OP_MOVI = 4'd7,
        OP_MOVS = 4'd8,
        OP_ADD  = 4'd9,
        OP_SUB  = 4'd10,
        OP_CALL = 4'd11,
        OP_RET  = 4'd12,
        OP_EMIT = 4'd13,
        OP_WAIT = 4'd14
    } op_e;

    localparam logic [PC_W:0] ONE = {{PC_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    // One extra bit so "every address already used" is visible as ptr_q[PC_W]
    // instead of silently wrapping to 0.
    logic [PC_W:0]     ptr_q, ptr_d;
    logic              wr_vld_q, wr_vld_d;
    logic [PC_W-1:0]   wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] wr_data_q, wr_data_d;
    logic              err_q, err_d;
    logic [PC_W:0]     prog_len_q, prog_len_d;

    logic [INST_W-1:0] enc;
    logic              enc_illegal;
    logic              in_rdy;
    logic              accept;
    logic              wr_fire;

    // Encoder: every field not listed for an opcode stays zero, so stray
    // values on unused inputs never leak into the word.
    always_comb begin
        enc         = '0;
        enc_illegal = 1'b0;
        case (bus.in_op)
            OP_NOP:  enc = '0;
            OP_JCC:  enc = {4'b0001, 2'b00, bus.in_cc, bus.in_target};
            OP_PUSH: enc = {4'b0010, 1'b0, bus.in_dst, 8'h00};
            OP_POP:  enc = {4'b0010, 1'b1, bus.in_dst, 8'h00};
            OP_LD:   enc = {4'b0100, 1'b0, bus.in_dst, 1'b0, bus.in_src0, 4'h0};
            OP_ST:   enc = {4'b0100, 1'b1, bus.in_dst, 1'b0, bus.in_src0, 4'h0};
            OP_MOV:  enc = {4'b0110, 1'b0, bus.in_dst, 1'b0, bus.in_src0, 4'h0};
            OP_MOVI: enc = {4'b0110, 1'b1, bus.in_dst, 1'b0, 3'b000, 1'b0, bus.in_imm};
            OP_MOVS: enc = {4'b0110, 1'b1, bus.in_dst, 1'b1, bus.in_special, 4'h0};
            OP_ADD, OP_SUB: begin
                enc = {4'b0111, (bus.in_op == OP_SUB), bus.in_dst, bus.in_wren,
                       bus.in_src0, bus.in_use_imm,
                       (bus.in_use_imm ? bus.in_imm : bus.in_src1)};
            end
            OP_CALL: enc = {4'b1100, 1'b1, 3'b000, bus.in_target};
            OP_RET:  enc = 16'hC000;
            OP_EMIT: enc = 16'hF000;
            OP_WAIT: enc = 16'hF800;
            default: begin
                enc         = '0;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Ready depends only on state and the output register so a source may
    // wait for in_rdy before raising in_vld without a combinational loop.
    assign in_rdy  = (state_q == S_LOAD) && (!wr_vld_q || bus.wr_rdy);
    assign accept  = bus.in_vld && in_rdy;
    assign wr_fire = wr_vld_q && bus.wr_rdy;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wr_vld_d   = wr_vld_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        prog_len_d = prog_len_q;

        if (wr_fire) begin
            wr_vld_d   = 1'b0;
            prog_len_d = prog_len_q + ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    ptr_d      = {1'b0, start_addr};
                    prog_len_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (ptr_q[PC_W]) begin
                        // Store exhausted: swallow the beat so the source
                        // can still drain up to its last instruction.
                        err_d = 1'b1;
                    end else begin
                        wr_vld_d  = 1'b1;
                        wr_addr_d = ptr_q[PC_W-1:0];
                        wr_data_d = enc;
                        ptr_d     = ptr_q + ONE;
                        if (enc_illegal) begin
                            err_d = 1'b1;
                        end
                    end
                    if (bus.in_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!wr_vld_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            wr_vld_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wr_vld_q   <= wr_vld_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            prog_len_q <= prog_len_d;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.wr_vld  = wr_vld_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    assign busy     = (state_q != S_IDLE);
    // Completion is the single FLUSH cycle in which the output register is empty.
    assign done     = (state_q == S_FLUSH) && !wr_vld_q;
    assign err      = err_q;
    assign prog_len = prog_len_q;

endmodule

// File: tb/tb_vert_ucode_quicksort_asm.sv
// tb/tb_vert_ucode_quicksort_asm.sv - self-checking bench for the ucode assembler
module tb_vert_ucode_quicksort_asm;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src0;
        logic [2:0]  src1;
        logic [2:0]  imm;
        logic [2:0]  special;
        logic [1:0]  cc;
        logic [7:0]  target;
        logic        use_imm;
        logic        wren;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] prog_len;

    vert_ucode_quicksort_asm_if #(.PC_W(8), .INST_W(16)) bus ();

    vert_ucode_quicksort_asm #(.PC_W(8), .INST_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .prog_len   (prog_len)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   model_ptr = 0;
    wr_t  sb_q[$];
    vec_t tbl[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a write seen valid&ready at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_vld === 1'b1 && bus.wr_rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", {24'h0, bus.wr_addr}, {24'h0, e.addr});
                check("wr_data", {16'h0, bus.wr_data}, {16'h0, e.data});
            end
            last_wr_cyc = cyc;
        end
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] src0,
                                input logic [2:0] src1, input logic [2:0] imm, input logic [2:0] special,
                                input logic [1:0] cc, input logic [7:0] target, input logic use_imm,
                                input logic wren, input logic [15:0] exp);
        vec_t v;
        v.op = op; v.dst = dst; v.src0 = src0; v.src1 = src1; v.imm = imm;
        v.special = special; v.cc = cc; v.target = target; v.use_imm = use_imm;
        v.wren = wren; v.exp = exp;
        return v;
    endfunction

    task automatic drive_fields(input vec_t v, input logic last);
        bus.in_op      = v.op;
        bus.in_dst     = v.dst;
        bus.in_src0    = v.src0;
        bus.in_src1    = v.src1;
        bus.in_imm     = v.imm;
        bus.in_special = v.special;
        bus.in_cc      = v.cc;
        bus.in_target  = v.target;
        bus.in_use_imm = v.use_imm;
        bus.in_wren    = v.wren;
        bus.in_last    = last;
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
    task automatic send(input vec_t v, input logic last, output int waits);
        wr_t e;
        drive_fields(v, last);
        bus.in_vld = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.in_rdy === 1'b1) break;
            waits++;
            if (waits > 50) begin
                check("in_rdy_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (model_ptr <= 255) begin
            e.addr = model_ptr[7:0];
            e.data = v.exp;
            sb_q.push_back(e);
        end
        model_ptr++;
        @(posedge clk);
        #1;
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic start_prog(input logic [7:0] a);
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start      = 1'b0;
        model_ptr  = a;
        @(negedge clk);
        check("busy_after_start", {31'h0, busy}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int exp_len, input logic exp_err);
        int n = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n > 100) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
        check("done_latency", cyc, last_wr_cyc + 1);
        check("prog_len", {23'h0, prog_len}, exp_len);
        check("err", {31'h0, err}, {31'h0, exp_err});
        check("sb_drained", sb_q.size(), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'h0, done}, 32'd0);
        check("busy_idle", {31'h0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_rdy"},   {31'h0, bus.in_rdy}, 32'd0);
        check({tag, "_wr_vld"},   {31'h0, bus.wr_vld}, 32'd0);
        check({tag, "_wr_addr"},  {24'h0, bus.wr_addr}, 32'd0);
        check({tag, "_wr_data"},  {16'h0, bus.wr_data}, 32'd0);
        check({tag, "_done"},     {31'h0, done}, 32'd0);
        check({tag, "_err"},      {31'h0, err}, 32'd0);
        check({tag, "_prog_len"}, {23'h0, prog_len}, 32'd0);
        check({tag, "_busy"},     {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        //        op  dst src0 src1 imm spc cc target  ui wr  expected
        tbl[0]  = mk(9,  3, 1, 2, 6, 5, 3, 8'hA5, 0, 1, 16'h7392); // ADD
        tbl[1]  = mk(10, 2, 0, 7, 5, 4, 1, 8'h5A, 1, 0, 16'h7A0D); // SUB imm
        tbl[2]  = mk(1,  5, 3, 6, 7, 7, 2, 8'h2A, 1, 1, 16'h122A); // JCC GT
        tbl[3]  = mk(11, 7, 7, 7, 7, 7, 3, 8'h40, 1, 1, 16'hC840); // CALL
        tbl[4]  = mk(12, 7, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'hC000); // RET
        tbl[5]  = mk(3,  6, 5, 4, 3, 2, 1, 8'h99, 1, 1, 16'h2E00); // POP r6
        tbl[6]  = mk(13, 7, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'hF000); // EMIT
        tbl[7]  = mk(14, 7, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'hF800); // WAIT
        tbl[8]  = mk(7,  5, 4, 3, 7, 6, 2, 8'h11, 1, 1, 16'h6D07); // MOVI r5,7
        tbl[9]  = mk(8,  1, 2, 3, 7, 0, 1, 8'h22, 1, 1, 16'h6980); // MOVS r1,REG_N
        tbl[10] = mk(2,  3, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'h2300); // PUSH r3
        tbl[11] = mk(4,  4, 2, 7, 7, 7, 3, 8'hFF, 1, 1, 16'h4420); // LD
        tbl[12] = mk(5,  1, 7, 6, 7, 7, 3, 8'hFF, 1, 1, 16'h4970); // ST
        tbl[13] = mk(6,  7, 5, 6, 7, 7, 3, 8'hFF, 1, 1, 16'h6750); // MOV
        tbl[14] = mk(0,  7, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'h0000); // NOP
        tbl[15] = mk(15, 7, 7, 7, 7, 7, 3, 8'hFF, 1, 1, 16'h0000); // illegal

        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = 8'h00;
        bus.in_vld = 1'b0;
        bus.wr_rdy = 1'b1;
        drive_fields(tbl[14], 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD / SUB program, done timing and length.
        start_prog(8'h10);
        send(tbl[0], 1'b0, w);
        send(tbl[1], 1'b1, w);
        wait_done(2, 1'b0);

        // Table sweep across every legal opcode with noise on unused fields;
        // a start pulse mid-program must be ignored.
        start_prog(8'h20);
        for (int i = 2; i <= 14; i++) begin
            send(tbl[i], (i == 14), w);
            if (i == 4) begin
                start      = 1'b1;
                start_addr = 8'h80;
                @(posedge clk);
                #1;
                start      = 1'b0;
            end
        end
        wait_done(13, 1'b0);

        // Back-pressure: output must hold while the store stalls, then run at 1 word/cycle.
        start_prog(8'h40);
        bus.wr_rdy = 1'b0;
        send(tbl[0], 1'b0, w);
        drive_fields(tbl[1], 1'b0);
        bus.in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_rdy",  {31'h0, bus.in_rdy}, 32'd0);
            check("stall_wr_vld",  {31'h0, bus.wr_vld}, 32'd1);
            check("stall_wr_addr", {24'h0, bus.wr_addr}, 32'h40);
            check("stall_wr_data", {16'h0, bus.wr_data}, {16'h0, tbl[0].exp});
        end
        @(posedge clk);
        #1;
        bus.wr_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send(tbl[i], (i == 3), w);
            check("b2b_waits", w, 32'd0);
        end
        wait_done(4, 1'b0);

        // Address overflow: third word has nowhere to go.
        start_prog(8'hFE);
        send(tbl[8], 1'b0, w);
        send(tbl[9], 1'b0, w);
        send(tbl[10], 1'b1, w);
        wait_done(2, 1'b1);

        // Illegal op occupies an address with a zero word and flags err.
        start_prog(8'h50);
        send(tbl[0], 1'b0, w);
        send(tbl[15], 1'b0, w);
        send(tbl[1], 1'b1, w);
        wait_done(3, 1'b1);

        // Reset while a write is pending.
        start_prog(8'h60);
        bus.wr_rdy = 1'b0;
        send(tbl[15], 1'b0, w);
        @(negedge clk);
        check("pre_reset_wr_vld", {31'h0, bus.wr_vld}, 32'd1);
        check("pre_reset_err",    {31'h0, err}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.wr_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Normal program after reset.
        start_prog(8'h70);
        check("post_reset_err_cleared", {31'h0, err}, 32'd0);
        send(tbl[13], 1'b1, w);
        wait_done(1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
